// File: rtl/carfield_pkg.sv
// Carfield shared types and constants used by the domain reset sequencer.
package carfield_pkg;

    localparam int unsigned NumDomains = 6;

    typedef enum logic [2:0] {
        PeriphDomain,
        SafedDomain,
        SecurityDomain,
        PulpDomain,
        SpatzDomain,
        L2Domain
    } carfield_domains_e;

    typedef enum logic [2:0] {
        DomHeld,
        DomReset,
        DomRelease,
        DomActive,
        DomIsolate
    } carfield_dom_state_e;

    localparam int unsigned CarDomRstCycles = 16;
    localparam int unsigned CarDomSettleCycles = 4;
    localparam int unsigned CarDomIsoTimeout = 255;
    localparam logic [NumDomains-1:0] CarDomBootOnMask = 6'b100001;

    function automatic int unsigned max3(
        int unsigned a,
        int unsigned b,
        int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/carfield_domain_rst_ctrl_if.sv
// Register-file side bundle of the per-domain reset/clock sequencer.
interface carfield_domain_rst_ctrl_if;
    import carfield_pkg::*;

    logic [NumDomains-1:0] rst_req_i;
    logic [NumDomains-1:0] clk_en_i;
    logic [NumDomains-1:0] isolated_i;
    logic [NumDomains-1:0] clk_en_o;
    logic [NumDomains-1:0] rst_no;
    logic [NumDomains-1:0] isolate_o;
    logic [NumDomains-1:0] done_o;
    logic [NumDomains-1:0] iso_timeout_o;
    logic                  busy_o;

    modport slave (
        input  rst_req_i, clk_en_i, isolated_i,
        output clk_en_o, rst_no, isolate_o,
        output done_o, iso_timeout_o, busy_o
    );

    modport master (
        output rst_req_i, clk_en_i, isolated_i,
        input  clk_en_o, rst_no, isolate_o,
        input  done_o, iso_timeout_o, busy_o
    );
endinterface

// File: rtl/carfield_domain_rst_fsm.sv
// One domain: HELD/RESET/RELEASE/ACTIVE/ISOLATE sequencer with a shared counter.
module carfield_domain_rst_fsm
    import carfield_pkg::*;
#(
    parameter int unsigned RstCycles    = CarDomRstCycles,
    parameter int unsigned SettleCycles = CarDomSettleCycles,
    parameter int unsigned IsoTimeout   = CarDomIsoTimeout
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic boot_on_i,
    input  logic rst_req_i,
    input  logic clk_en_i,
    input  logic isolated_i,
    output logic clk_en_o,
    output logic rst_no,
    output logic isolate_o,
    output logic done_o,
    output logic iso_timeout_o,
    output logic busy_o
);

    localparam int unsigned CntMax = max3(RstCycles, SettleCycles, IsoTimeout);
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] RstLoad = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] SetLoad = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] IsoLast =
        CntW'((IsoTimeout == 0) ? 0 : IsoTimeout - 1);

    carfield_dom_state_e state_q;
    logic [CntW-1:0]     cnt_q;
    logic                first_q;
    logic                iso_expired;

    // Leaving ISOLATE on the cycle the count would reach IsoTimeout
    assign iso_expired = (IsoTimeout != 0) && (cnt_q == IsoLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= DomHeld;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            clk_en_o      <= 1'b0;
            rst_no        <= 1'b0;
            isolate_o     <= 1'b1;
            done_o        <= 1'b0;
            iso_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            first_q <= 1'b0;
            done_o  <= 1'b0;
            unique case (state_q)
                DomHeld: begin
                    if ((first_q && boot_on_i) || rst_req_i) begin
                        state_q  <= DomReset;
                        cnt_q    <= RstLoad;
                        clk_en_o <= 1'b1;
                        busy_o   <= 1'b1;
                    end
                end
                DomReset: begin
                    if (cnt_q == '0) begin
                        state_q <= DomRelease;
                        cnt_q   <= SetLoad;
                        rst_no  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DomRelease: begin
                    if (rst_req_i) begin
                        state_q <= DomReset;
                        cnt_q   <= RstLoad;
                        rst_no  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q   <= DomActive;
                        isolate_o <= 1'b0;
                        clk_en_o  <= clk_en_i;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DomActive: begin
                    if (rst_req_i) begin
                        state_q   <= DomIsolate;
                        cnt_q     <= '0;
                        isolate_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end else begin
                        clk_en_o <= clk_en_i;
                    end
                end
                DomIsolate: begin
                    if (isolated_i || iso_expired) begin
                        state_q  <= DomReset;
                        cnt_q    <= RstLoad;
                        rst_no   <= 1'b0;
                        clk_en_o <= 1'b1;
                        if (!isolated_i) iso_timeout_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= DomHeld;
                    clk_en_o  <= 1'b0;
                    rst_no    <= 1'b0;
                    isolate_o <= 1'b1;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/carfield_domain_rst_ctrl.sv
// Per-domain reset/clock-enable sequencer for the gateable Carfield subdomains.
module carfield_domain_rst_ctrl
    import carfield_pkg::*;
#(
    parameter logic [NumDomains-1:0] BootOnMask = CarDomBootOnMask,
    parameter int unsigned RstCycles    = CarDomRstCycles,
    parameter int unsigned SettleCycles = CarDomSettleCycles,
    parameter int unsigned IsoTimeout   = CarDomIsoTimeout
) (
    input logic clk_i,
    input logic rst_ni,
    carfield_domain_rst_ctrl_if.slave bus
);

    logic [NumDomains-1:0] clk_en;
    logic [NumDomains-1:0] rst_n;
    logic [NumDomains-1:0] isolate;
    logic [NumDomains-1:0] done;
    logic [NumDomains-1:0] iso_timeout;
    logic [NumDomains-1:0] busy;

    for (genvar d = 0; d < NumDomains; d++) begin : gen_dom
        carfield_domain_rst_fsm #(
            .RstCycles    (RstCycles),
            .SettleCycles (SettleCycles),
            .IsoTimeout   (IsoTimeout)
        ) u_fsm (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .boot_on_i     (BootOnMask[d]),
            .rst_req_i     (bus.rst_req_i[d]),
            .clk_en_i      (bus.clk_en_i[d]),
            .isolated_i    (bus.isolated_i[d]),
            .clk_en_o      (clk_en[d]),
            .rst_no        (rst_n[d]),
            .isolate_o     (isolate[d]),
            .done_o        (done[d]),
            .iso_timeout_o (iso_timeout[d]),
            .busy_o        (busy[d])
        );
    end

    assign bus.clk_en_o      = clk_en;
    assign bus.rst_no        = rst_n;
    assign bus.isolate_o     = isolate;
    assign bus.done_o        = done;
    assign bus.iso_timeout_o = iso_timeout;
    assign bus.busy_o        = |busy;

endmodule

// File: tb/tb_carfield_domain_rst_ctrl.sv
// Bench for carfield_domain_rst_ctrl: timed expectations checked from a queue.
module tb_carfield_domain_rst_ctrl;
    import carfield_pkg::*;

    localparam int SClk = 0;
    localparam int SRst = 1;
    localparam int SIso = 2;
    localparam int SDone = 3;
    localparam int STmo = 4;
    localparam int SBusy = 5;

    typedef struct {
        int         at;
        string      name;
        int         s;
        logic [5:0] m;
        logic [5:0] v;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t boot_tbl[13];

    carfield_domain_rst_ctrl_if bus();

    carfield_domain_rst_ctrl dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [5:0] sig(int s);
        case (s)
            SClk:    return bus.clk_en_o;
            SRst:    return bus.rst_no;
            SIso:    return bus.isolate_o;
            SDone:   return bus.done_o;
            STmo:    return bus.iso_timeout_o;
            default: return {5'b0, bus.busy_o};
        endcase
    endfunction

    task automatic chk(string n, logic [5:0] got, logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, got, exp);
        end
    endtask

    task automatic push(int at, string n, int s, logic [5:0] m, logic [5:0] v);
        vec_t e;
        e.at = at; e.name = n; e.s = s; e.m = m; e.v = v;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk_reset_vals(string n);
        chk({n, "_clk"}, bus.clk_en_o, 6'h00);
        chk({n, "_rst"}, bus.rst_no, 6'h00);
        chk({n, "_iso"}, bus.isolate_o, 6'h3F);
        chk({n, "_done"}, bus.done_o, 6'h00);
        chk({n, "_tmo"}, bus.iso_timeout_o, 6'h00);
        chk({n, "_busy"}, {5'b0, bus.busy_o}, 6'h00);
    endtask

    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: missed slot %0d", sb[i].name, sb[i].at);
                sb.delete(i);
            end else if (sb[i].at == cyc) begin
                chk(sb[i].name, sig(sb[i].s) & sb[i].m, sb[i].v);
                sb.delete(i);
            end
        end
    end

    initial begin
        int t;
        int c0;
        bus.rst_req_i = '0;
        bus.clk_en_i = 6'h3F;
        bus.isolated_i = '0;

        boot_tbl[0]  = '{1,  "boot_rst1",   SRst,  6'h3F, 6'h00};
        boot_tbl[1]  = '{1,  "boot_clk1",   SClk,  6'h3F, 6'h21};
        boot_tbl[2]  = '{1,  "boot_busy1",  SBusy, 6'h01, 6'h01};
        boot_tbl[3]  = '{16, "boot_rst16",  SRst,  6'h3F, 6'h00};
        boot_tbl[4]  = '{17, "boot_rst17",  SRst,  6'h3F, 6'h21};
        boot_tbl[5]  = '{17, "boot_iso17",  SIso,  6'h3F, 6'h3F};
        boot_tbl[6]  = '{20, "boot_iso20",  SIso,  6'h3F, 6'h3F};
        boot_tbl[7]  = '{20, "boot_done20", SDone, 6'h3F, 6'h00};
        boot_tbl[8]  = '{21, "boot_done21", SDone, 6'h3F, 6'h21};
        boot_tbl[9]  = '{21, "boot_iso21",  SIso,  6'h3F, 6'h1E};
        boot_tbl[10] = '{21, "boot_busy21", SBusy, 6'h01, 6'h00};
        boot_tbl[11] = '{21, "boot_clk21",  SClk,  6'h3F, 6'h21};
        boot_tbl[12] = '{22, "boot_done22", SDone, 6'h3F, 6'h00};

        step(2);
        chk_reset_vals("por");
        rst_ni = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 13; i++)
            push(c0 + boot_tbl[i].at, boot_tbl[i].name, boot_tbl[i].s,
                 boot_tbl[i].m, boot_tbl[i].v);
        step(23);

        // soft reset of a held domain
        t = cyc;
        bus.rst_req_i = 6'h08;
        for (int k = 1; k <= 16; k++) begin
            push(t + k, "d3_rst_low", SRst, 6'h08, 6'h00);
            push(t + k, "d3_clk_on", SClk, 6'h08, 6'h08);
        end
        push(t + 17, "d3_rst_rel", SRst, 6'h08, 6'h08);
        push(t + 20, "d3_iso_hold", SIso, 6'h08, 6'h08);
        push(t + 21, "d3_iso_drop", SIso, 6'h08, 6'h00);
        push(t + 21, "d3_done", SDone, 6'h08, 6'h08);
        step(1);
        bus.rst_req_i = '0;
        step(22);

        // clock enable follows the level with one cycle of lag
        t = cyc;
        bus.clk_en_i = 6'h3E;
        push(t + 1, "d0_clk_off", SClk, 6'h01, 6'h00);
        step(2);

        // isolation handshake acknowledged late
        t = cyc;
        bus.rst_req_i = 6'h01;
        push(t + 1, "d0_iso_req", SIso, 6'h01, 6'h01);
        push(t + 1, "d0_busy", SBusy, 6'h01, 6'h01);
        push(t + 5, "d0_clk_hold", SClk, 6'h01, 6'h00);
        push(t + 11, "d0_rst_wait", SRst, 6'h01, 6'h01);
        push(t + 12, "d0_rst_low", SRst, 6'h01, 6'h00);
        push(t + 12, "d0_clk_rst", SClk, 6'h01, 6'h01);
        push(t + 12, "d0_no_tmo", STmo, 6'h01, 6'h00);
        push(t + 27, "d0_rst_27", SRst, 6'h01, 6'h00);
        push(t + 28, "d0_rst_rel", SRst, 6'h01, 6'h01);
        push(t + 31, "d0_done_31", SDone, 6'h01, 6'h00);
        push(t + 32, "d0_done", SDone, 6'h01, 6'h01);
        push(t + 32, "d0_clk_samp", SClk, 6'h01, 6'h00);
        push(t + 32, "d0_iso_off", SIso, 6'h01, 6'h00);
        step(1);
        bus.rst_req_i = '0;
        step(10);
        bus.isolated_i = 6'h01;
        step(23);

        // isolation never acknowledged
        t = cyc;
        bus.rst_req_i = 6'h20;
        push(t + 1, "d5_iso_req", SIso, 6'h20, 6'h20);
        push(t + 255, "d5_rst_wait", SRst, 6'h20, 6'h20);
        push(t + 255, "d5_tmo_pre", STmo, 6'h21, 6'h00);
        push(t + 256, "d5_rst_low", SRst, 6'h20, 6'h00);
        push(t + 256, "d5_tmo_set", STmo, 6'h21, 6'h20);
        push(t + 276, "d5_done", SDone, 6'h20, 6'h20);
        push(t + 276, "d5_tmo_sticky", STmo, 6'h3F, 6'h20);
        step(1);
        bus.rst_req_i = '0;
        step(279);

        // simultaneous requests from mixed states
        t = cyc;
        bus.rst_req_i = 6'h10;
        step(1);
        bus.rst_req_i = '0;
        step(1);
        bus.rst_req_i = 6'h02;
        step(1);
        bus.rst_req_i = '0;
        push(t + 18, "mix_rst_18", SRst, 6'h12, 6'h10);
        push(t + 18, "mix_iso_18", SIso, 6'h3F, 6'h16);
        push(t + 19, "mix_rst_19", SRst, 6'h3F, 6'h2B);
        push(t + 19, "mix_iso_19", SIso, 6'h3F, 6'h3F);
        push(t + 20, "mix_rst_20", SRst, 6'h3F, 6'h2A);
        push(t + 22, "mix_rst_22", SRst, 6'h3F, 6'h02);
        push(t + 24, "mix_rst_24", SRst, 6'h3F, 6'h02);
        push(t + 24, "mix_clk_24", SClk, 6'h3F, 6'h3F);
        step(15);
        bus.rst_req_i = 6'h3F;
        step(1);
        bus.rst_req_i = '0;
        step(2);
        bus.isolated_i = 6'h29;
        step(4);

        // asynchronous reset in the middle of domain 2's reset
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("async");
        step(2);
        bus.isolated_i = '0;
        bus.clk_en_i = 6'h3F;
        rst_ni = 1'b1;
        c0 = cyc;
        push(c0 + 1, "reboot_rst", SRst, 6'h3F, 6'h00);
        push(c0 + 1, "reboot_clk", SClk, 6'h3F, 6'h21);
        push(c0 + 21, "reboot_done", SDone, 6'h3F, 6'h21);
        push(c0 + 21, "reboot_tmo", STmo, 6'h3F, 6'h00);

        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
